regfile_write_sequencer: RTL and testbench

- Sequences register-file writes for the SEQ write-back stage onto a single write port.
- Accepts one retired instruction per handshake and decodes its E and M destinations from icode/rA/rB.
- Issues the writes in a fixed order: E first, then M; popq therefore takes two port cycles.
- Exports a pending-write mask for the decode interlock, plus a retire pulse, halt and error status.

---
 rtl/regfile_write_sequencer.sv | 158 +++++++++++++++
 tb/tb_regfile_write_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_write_sequencer
// Purpose  : Serialises the SEQ write-back stage's E and M register writes
//            onto a single register-file write port (E first, then M).
//            Exports a pending-write mask for the decode interlock, a retire
//            pulse, and sticky halt / error status.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            wb_valid/wb_ready  - instruction handshake from write-back
//            icode,cnd,rA,rB    - instruction fields used to decode dstE/dstM
//            valE, valM         - ALU result / memory read data
//            rf_we/waddr/wdata  - registered register-file write port
//            pend_mask          - one bit per register with a write outstanding
//            retire             - pulse in the cycle of an instruction's last write
//            halted, err        - sticky status (halt/invalid, invalid only)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sequencer #(
  parameter int          DATA_W = 64,
  parameter logic [3:0]  RNONE  = 4'hF,
  parameter logic [3:0]  RSP    = 4'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       pend_mask,
  output logic              retire,
  output logic              halted,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_E = 2'd1,
    S_WR_M = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_dst_m, w_dst_m_nxt;
  logic [DATA_W-1:0]  r_val_m, w_val_m_nxt;

  logic               w_we_nxt, w_retire_nxt;
  logic [3:0]         w_waddr_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt;
  logic [15:0]        w_mask_nxt;

  logic [3:0]         w_dec_e, w_dec_m;
  logic               w_invalid, w_accept;

  // One-hot register bit; the "no register" ID and bit 15 never appear.
  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    logic [15:0] b;
    b = (r == RNONE) ? 16'h0000 : (16'h0001 << r);
    return b & 16'h7FFF;
  endfunction

  // Destination decode from the incoming instruction.
  always_comb begin
    w_dec_e = RNONE;
    case (icode)
      4'h2:                   if (cnd) w_dec_e = rB;
      4'h3, 4'h6:             w_dec_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: w_dec_e = RSP;
      default:                w_dec_e = RNONE;
    endcase
    w_dec_m = ((icode == 4'h5) || (icode == 4'hB)) ? rA : RNONE;
  end

  assign w_invalid = (icode > 4'hB);

  // Ready whenever the current cycle is not a WR_E with an M write still due.
  assign wb_ready = !halted &&
                    ((r_state != S_WR_E) || (r_dst_m == RNONE));
  assign w_accept = wb_valid && wb_ready;

  always_comb begin
    w_state_nxt  = S_IDLE;
    w_dst_m_nxt  = r_dst_m;
    w_val_m_nxt  = r_val_m;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = 4'h0;
    w_wdata_nxt  = '0;
    w_retire_nxt = 1'b0;
    w_mask_nxt   = 16'h0000;

    if ((r_state == S_WR_E) && (r_dst_m != RNONE)) begin
      w_state_nxt = S_WR_M;
    end else if (w_accept) begin
      w_dst_m_nxt = w_dec_m;
      w_val_m_nxt = valM;
      if (w_dec_e != RNONE)
        w_state_nxt = S_WR_E;
      else if (w_dec_m != RNONE)
        w_state_nxt = S_WR_M;
      else
        w_retire_nxt = !w_invalid;  // zero-write instruction retires at once
    end

    // The E write is only entered straight from an accept, so the freshly
    // decoded dstE / valE inputs are the ones to drive.
    case (w_state_nxt)
      S_WR_E: begin
        w_we_nxt     = 1'b1;
        w_waddr_nxt  = w_dec_e;
        w_wdata_nxt  = valE;
        w_retire_nxt = (w_dst_m_nxt == RNONE);
        w_mask_nxt   = reg_bit(w_dec_e) | reg_bit(w_dst_m_nxt);
      end
      S_WR_M: begin
        w_we_nxt     = 1'b1;
        w_waddr_nxt  = w_dst_m_nxt;
        w_wdata_nxt  = w_val_m_nxt;
        w_retire_nxt = 1'b1;
        w_mask_nxt   = reg_bit(w_dst_m_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dst_m   <= RNONE;
      r_val_m   <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= 4'h0;
      rf_wdata  <= '0;
      pend_mask <= 16'h0000;
      retire    <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dst_m   <= w_dst_m_nxt;
      r_val_m   <= w_val_m_nxt;
      rf_we     <= w_we_nxt;
      rf_waddr  <= w_waddr_nxt;
      rf_wdata  <= w_wdata_nxt;
      pend_mask <= w_mask_nxt;
      retire    <= w_retire_nxt;
      halted    <= halted | (w_accept && ((icode == 4'h0) || w_invalid));
      err       <= err | (w_accept && w_invalid);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sequencer
// Purpose  : Self-checking bench for regfile_write_sequencer. The reference
//            model expands each accepted instruction into the list of port
//            cycles it must produce and compares the DUT cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sequencer;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        icode;
  logic              cnd;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [15:0]       pend_mask;
  logic              retire;
  logic              halted;
  logic              err;

  always #5 clk = ~clk;

  regfile_write_sequencer #(.DATA_W(DATA_W), .RNONE(4'hF), .RSP(4'h4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .retire(retire), .halted(halted), .err(err)
  );

  // One port cycle the DUT owes us.
  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [63:0] d;
    logic        ret;
    logic [15:0] mask;
    logic        last;
    logic        hlt;
    logic        er;
  } slot_t;

  slot_t q[$];
  logic  m_halted;
  logic  m_err;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bit_of(input logic [3:0] r);
    return (r == 4'hF) ? 16'h0000 : (16'h0001 << r);
  endfunction

  // Expand an instruction into its port cycles using the ISA rules directly.
  task automatic model_push(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
    logic [3:0] e, m;
    logic bad;
    slot_t s;
    bad = (ic > 4'hB);
    if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) e = rb;
    else if (ic >= 4'h8 && ic <= 4'hB)                 e = 4'h4;
    else                                               e = 4'hF;
    m = (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    s.we = 1'b0; s.a = 4'h0; s.d = 64'h0; s.ret = 1'b0; s.mask = 16'h0;
    s.last = 1'b1; s.hlt = 1'b0; s.er = 1'b0;
    if (e == 4'hF && m == 4'hF) begin
      s.ret = !bad;
      s.hlt = (ic == 4'h0) || bad;
      s.er  = bad;
      q.push_back(s);
    end else begin
      if (e != 4'hF) begin
        s.we = 1'b1; s.a = e; s.d = ve;
        s.ret = (m == 4'hF); s.last = (m == 4'hF);
        s.mask = bit_of(e) | bit_of(m);
        q.push_back(s);
      end
      if (m != 4'hF) begin
        s.we = 1'b1; s.a = m; s.d = vm;
        s.ret = 1'b1; s.last = 1'b1;
        s.mask = bit_of(m);
        q.push_back(s);
      end
    end
  endtask

  // Offer (or not) one instruction for one clock, then check the new cycle.
  task automatic cyc(input logic v, input logic [3:0] ic, input logic c, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
    logic  exp_rdy, acc;
    slot_t cur;
    wb_valid = v; icode = ic; cnd = c; rA = ra; rB = rb; valE = ve; valM = vm;
    exp_rdy = !m_halted && (q.size() == 0 || q[0].last);
    chk("wb_ready", 64'(wb_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) model_push(ic, c, ra, rb, ve, vm);
    #1;
    if (q.size() > 0) cur = q[0];
    else begin
      cur.we = 1'b0; cur.a = 4'h0; cur.d = 64'h0; cur.ret = 1'b0; cur.mask = 16'h0;
      cur.last = 1'b1; cur.hlt = 1'b0; cur.er = 1'b0;
    end
    m_halted = m_halted | cur.hlt;
    m_err    = m_err | cur.er;
    chk("rf_we", 64'(rf_we), 64'(cur.we));
    if (cur.we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(cur.a));
      chk("rf_wdata", rf_wdata, cur.d);
    end
    chk("retire", 64'(retire), 64'(cur.ret));
    chk("pend_mask", 64'(pend_mask), 64'(cur.mask));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_halted = 1'b0;
    m_err = 1'b0;
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_rf_wdata", rf_wdata, 64'h0);
    chk("rst_pend_mask", 64'(pend_mask), 64'h0);
    chk("rst_retire", 64'(retire), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; cnd = 1'b0;
    rA = 4'hF; rB = 4'hF; valE = '0; valM = '0;
    m_halted = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // irmovq rB=3
    cyc(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'h1234, 64'h0);
    idle_cyc();
    // popq rA=2, with an OPq waiting behind it
    cyc(1'b1, 4'hB, 1'b0, 4'h2, 4'hF, 64'h108, 64'hABCD);
    cyc(1'b1, 4'h6, 1'b0, 4'h0, 4'h5, 64'h99, 64'h0);
    cyc(1'b1, 4'h6, 1'b0, 4'h0, 4'h5, 64'h99, 64'h0);
    idle_cyc();
    // popq %rsp
    cyc(1'b1, 4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55);
    idle_cyc();
    idle_cyc();
    // cmovXX not taken, then taken
    cyc(1'b1, 4'h2, 1'b0, 4'h0, 4'h6, 64'h7, 64'h0);
    cyc(1'b1, 4'h2, 1'b1, 4'h0, 4'h6, 64'h7, 64'h0);
    idle_cyc();
    // back-to-back OPq
    cyc(1'b1, 4'h6, 1'b0, 4'h0, 4'h1, 64'h11, 64'h0);
    cyc(1'b1, 4'h6, 1'b0, 4'h0, 4'h2, 64'h22, 64'h0);
    cyc(1'b1, 4'h6, 1'b0, 4'h0, 4'h3, 64'h33, 64'h0);
    idle_cyc();
    // zero-write instructions, then mrmovq and call/ret
    cyc(1'b1, 4'h1, 1'b0, 4'h3, 4'h3, 64'h1, 64'h2);
    cyc(1'b1, 4'h7, 1'b1, 4'h3, 4'h3, 64'h1, 64'h2);
    cyc(1'b1, 4'h4, 1'b0, 4'h3, 4'h3, 64'h1, 64'h2);
    cyc(1'b1, 4'h5, 1'b0, 4'h9, 4'h3, 64'h1, 64'hBEEF);
    cyc(1'b1, 4'h8, 1'b0, 4'h9, 4'h3, 64'hF0, 64'h0);
    cyc(1'b1, 4'h9, 1'b0, 4'h9, 4'h3, 64'hF8, 64'h0);
    idle_cyc();

    // randomized non-halting traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle_cyc();
    idle_cyc();

    // reset during WR_E of a popq abandons the M write
    cyc(1'b1, 4'hB, 1'b0, 4'h2, 4'hF, 64'h108, 64'hABCD);
    do_reset();
    idle_cyc();
    // halt: retires, then blocks further instructions
    cyc(1'b1, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
    cyc(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'h77, 64'h0);
    cyc(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'h77, 64'h0);
    cyc(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'h77, 64'h0);
    // invalid icode: err and halted, no retire
    do_reset();
    cyc(1'b1, 4'hD, 1'b0, 4'h1, 4'h1, 64'h5, 64'h6);
    cyc(1'b1, 4'h6, 1'b0, 4'h1, 4'h1, 64'h5, 64'h6);
    idle_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
